// File: rtl/srl_pkg.sv
// Shared constants and elaboration helpers for the SRL shift-register LUT family.
// Provides clog2 and the WIDTH/DEPTH legality check used at elaboration time.
package srl_pkg;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned MAX_DEPTH = 64;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // DEPTH must be a power of two in 2..MAX_DEPTH; WIDTH in 1..MAX_WIDTH.
  function automatic bit params_legal(input int unsigned width, input int unsigned depth);
    return (width >= 1) && (width <= MAX_WIDTH) &&
           (depth >= 2) && (depth <= MAX_DEPTH) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/srl_fill_ctr.sv
// Saturating shift counter: counts shifts since reset and holds at DEPTH.
// Clocked on whichever edge the parent has already selected as active.
module srl_fill_ctr
  import srl_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  output logic [AW:0] count
);

  localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

  logic [AW:0] count_q = '0;
  logic [AW:0] count_d;

  always_comb begin
    count_d = count_q;
    if (CE && (count_q < Full)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/srl_shift_lut.sv
// Per-lane addressable shift register (SRL-style) with optional registered tap,
// selectable active clock edge, and a fill counter that qualifies the tap.
module srl_shift_lut
  import srl_pkg::*;
#(
  parameter int unsigned              WIDTH   = 1,
  parameter int unsigned              DEPTH   = 16,
  parameter logic [WIDTH*DEPTH-1:0]   INIT    = '0,
  parameter bit                       REG_OUT = 1'b0,
  parameter bit                       CLK_INV = 1'b0,
  localparam int unsigned             AW      = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic [WIDTH-1:0] Q_CASC,
  output logic [AW:0]      FILL
);

  if (!params_legal(WIDTH, DEPTH)) begin : g_illegal
    $error("srl_shift_lut: illegal WIDTH=%0d or DEPTH=%0d", WIDTH, DEPTH);
  end

  logic clk_act;
  assign clk_act = CLK ^ CLK_INV;

  // Packed so that flat bit i*WIDTH+j is stage i, lane j, matching INIT.
  logic [DEPTH-1:0][WIDTH-1:0] stage_q = INIT;

  always_ff @(posedge clk_act) begin
    if (RST) begin
      stage_q <= INIT;
    end else if (CE) begin
      stage_q <= {stage_q[DEPTH-2:0], D};
    end
  end

  logic [AW:0] fill;

  srl_fill_ctr #(
    .DEPTH (DEPTH)
  ) u_fill_ctr (
    .CLK   (clk_act),
    .RST   (RST),
    .CE    (CE),
    .count (fill)
  );

  logic [WIDTH-1:0] tap;
  logic             tap_valid;

  assign tap       = stage_q[A];
  assign tap_valid = (fill > {1'b0, A});

  if (REG_OUT) begin : g_reg_out
    logic [WIDTH-1:0] q_q     = INIT[WIDTH-1:0];
    logic             valid_q = 1'b0;

    // Tap register runs every active edge so A changes show up without a shift.
    always_ff @(posedge clk_act) begin
      if (RST) begin
        q_q     <= INIT[WIDTH-1:0];
        valid_q <= 1'b0;
      end else begin
        q_q     <= tap;
        valid_q <= tap_valid;
      end
    end

    assign Q       = q_q;
    assign Q_VALID = valid_q;
  end else begin : g_comb_out
    assign Q       = tap;
    assign Q_VALID = tap_valid;
  end

  assign Q_CASC = stage_q[DEPTH-1];
  assign FILL   = fill;

endmodule

// File: tb/tb_srl_shift_lut.sv
// Directed bench for srl_shift_lut: vector table for the basic 1x16 lane plus
// hand sequences for multi-lane, INIT, registered-tap and falling-edge variants.
module tb_srl_shift_lut;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn();
    @(negedge clk);
    #1;
  endtask

  // u0: WIDTH=1 DEPTH=16 INIT=0, combinational tap
  logic       r0 = 1'b0, c0 = 1'b0, d0 = 1'b0;
  logic [3:0] a0 = '0;
  logic       q0, v0, cs0;
  logic [4:0] f0;
  srl_shift_lut #(.WIDTH(1), .DEPTH(16), .INIT(16'h0000), .REG_OUT(1'b0), .CLK_INV(1'b0)) u0 (
    .CLK(clk), .RST(r0), .CE(c0), .D(d0), .A(a0), .Q(q0), .Q_VALID(v0), .Q_CASC(cs0), .FILL(f0)
  );

  // u1: WIDTH=4 DEPTH=8
  logic       r1 = 1'b0, c1 = 1'b0;
  logic [3:0] d1 = '0;
  logic [2:0] a1 = '0;
  logic [3:0] q1, cs1;
  logic       v1;
  logic [3:0] f1;
  srl_shift_lut #(.WIDTH(4), .DEPTH(8), .INIT(32'h0), .REG_OUT(1'b0), .CLK_INV(1'b0)) u1 (
    .CLK(clk), .RST(r1), .CE(c1), .D(d1), .A(a1), .Q(q1), .Q_VALID(v1), .Q_CASC(cs1), .FILL(f1)
  );

  // u2: INIT=16'h8001, combinational tap
  logic       r2 = 1'b0, c2 = 1'b0, d2 = 1'b0;
  logic [3:0] a2 = '0;
  logic       q2, v2, cs2;
  logic [4:0] f2;
  srl_shift_lut #(.WIDTH(1), .DEPTH(16), .INIT(16'h8001), .REG_OUT(1'b0), .CLK_INV(1'b0)) u2 (
    .CLK(clk), .RST(r2), .CE(c2), .D(d2), .A(a2), .Q(q2), .Q_VALID(v2), .Q_CASC(cs2), .FILL(f2)
  );

  // u3: INIT=16'h8001, registered tap
  logic       r3 = 1'b0, c3 = 1'b0, d3 = 1'b0;
  logic [3:0] a3 = '0;
  logic       q3, v3, cs3;
  logic [4:0] f3;
  srl_shift_lut #(.WIDTH(1), .DEPTH(16), .INIT(16'h8001), .REG_OUT(1'b1), .CLK_INV(1'b0)) u3 (
    .CLK(clk), .RST(r3), .CE(c3), .D(d3), .A(a3), .Q(q3), .Q_VALID(v3), .Q_CASC(cs3), .FILL(f3)
  );

  // u4: falling-edge active
  logic       r4 = 1'b0, c4 = 1'b0, d4 = 1'b0;
  logic [3:0] a4 = '0;
  logic       q4, v4, cs4;
  logic [4:0] f4;
  srl_shift_lut #(.WIDTH(1), .DEPTH(16), .INIT(16'h0000), .REG_OUT(1'b0), .CLK_INV(1'b1)) u4 (
    .CLK(clk), .RST(r4), .CE(c4), .D(d4), .A(a4), .Q(q4), .Q_VALID(v4), .Q_CASC(cs4), .FILL(f4)
  );

  typedef struct {
    logic       rst, ce, d;
    logic [3:0] a;
    logic       q, v, casc;
    logic [4:0] fill;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic ce, input logic d, input int a,
                              input logic q, input logic v, input logic casc, input int fill);
    vec_t t;
    t.rst = rst; t.ce = ce; t.d = d; t.a = 4'(a);
    t.q = q; t.v = v; t.casc = casc; t.fill = 5'(fill);
    vecs.push_back(t);
  endfunction

  initial begin
    // Contents hold INIT before any edge, without reset.
    #1;
    chk("u2_t0_q", q2, 1'b1);
    chk("u2_t0_casc", cs2, 1'b1);
    chk("u2_t0_fill", f2, 5'd0);
    chk("u3_t0_q", q3, 1'b1);
    chk("u3_t0_valid", v3, 1'b0);

    // Single 1 walks to stage 15, then saturates and drops off the end.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0, 1);
    for (int k = 2; k <= 15; k++) add(0, 1, 0, 15, 0, 0, 0, k);
    add(0, 1, 0, 15, 1, 1, 1, 16);
    add(0, 1, 0, 15, 0, 1, 0, 16);
    // Ten shifts, then reset with CE=1 and D=1 on the same edge.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) add(0, 1, 1, 0, 1, 1, 0, k);
    add(1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 15, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 2, 0, 0, 0, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      r0 = vecs[i].rst; c0 = vecs[i].ce; d0 = vecs[i].d; a0 = vecs[i].a;
      tick();
      chk($sformatf("u0_q[%0d]", i), q0, vecs[i].q);
      chk($sformatf("u0_valid[%0d]", i), v0, vecs[i].v);
      chk($sformatf("u0_casc[%0d]", i), cs0, vecs[i].casc);
      chk($sformatf("u0_fill[%0d]", i), f0, vecs[i].fill);
    end
    r0 = 0; c0 = 0;

    // 4-lane: CE toggling, only CE=1 cycles shift.
    r1 = 1; tick(); r1 = 0;
    chk("u1_rst_fill", f1, 4'd0);
    c1 = 1; d1 = 4'hA; tick();
    chk("u1_s1_q", q1, 4'hA); chk("u1_s1_fill", f1, 4'd1);
    c1 = 0; d1 = 4'hF; tick();
    chk("u1_h1_q", q1, 4'hA); chk("u1_h1_fill", f1, 4'd1);
    c1 = 1; d1 = 4'h5; tick();
    chk("u1_s2_q", q1, 4'h5); chk("u1_s2_fill", f1, 4'd2);
    c1 = 0; d1 = 4'hF; tick();
    chk("u1_h2_q", q1, 4'h5); chk("u1_h2_fill", f1, 4'd2);
    c1 = 1; d1 = 4'h3; tick();
    chk("u1_s3_q", q1, 4'h3); chk("u1_s3_fill", f1, 4'd3);
    c1 = 0; a1 = 3'd2; #1;
    chk("u1_a2_q", q1, 4'hA); chk("u1_a2_valid", v1, 1'b1);
    a1 = 3'd1; #1;
    chk("u1_a1_q", q1, 4'h5);
    a1 = 3'd3; #1;
    chk("u1_a3_q", q1, 4'h0); chk("u1_a3_valid", v1, 1'b0);

    // INIT=8001 after reset, then three zero shifts.
    r2 = 1; tick(); r2 = 0;
    a2 = 4'd0; #1;
    chk("u2_a0_q", q2, 1'b1); chk("u2_a0_valid", v2, 1'b0);
    a2 = 4'd15; #1;
    chk("u2_a15_q", q2, 1'b1); chk("u2_casc", cs2, 1'b1); chk("u2_a15_valid", v2, 1'b0);
    c2 = 1; d2 = 0;
    for (int k = 0; k < 3; k++) tick();
    c2 = 0;
    chk("u2_fill3", f2, 5'd3);
    a2 = 4'd2; #1;
    chk("u2_a2_valid", v2, 1'b1); chk("u2_a2_q", q2, 1'b0);
    a2 = 4'd3; #1;
    chk("u2_a3_valid", v2, 1'b0); chk("u2_a3_q", q2, 1'b1);
    chk("u2_casc_after", cs2, 1'b0);

    // Registered tap: one edge of latency from A or shift.
    r3 = 1; c3 = 1; d3 = 0; a3 = 4'd7; tick(); r3 = 0; c3 = 0;
    chk("u3_rst_q", q3, 1'b1); chk("u3_rst_valid", v3, 1'b0);
    a3 = 4'd0; tick();
    chk("u3_a0_q", q3, 1'b1);
    a3 = 4'd5; #1;
    chk("u3_a5_pre_q", q3, 1'b1);
    tick();
    chk("u3_a5_q", q3, 1'b0); chk("u3_a5_valid", v3, 1'b0);
    a3 = 4'd0; c3 = 1; d3 = 1; tick(); c3 = 0;
    chk("u3_sh_q", q3, 1'b1); chk("u3_sh_valid", v3, 1'b0); chk("u3_sh_fill", f3, 5'd1);
    tick();
    chk("u3_lat_q", q3, 1'b1); chk("u3_lat_valid", v3, 1'b1);
    a3 = 4'd15; tick();
    chk("u3_a15_q", q3, 1'b0); chk("u3_a15_valid", v3, 1'b0);

    // Falling-edge variant of the single-bit walk.
    r4 = 1; tickn(); r4 = 0;
    chk("u4_rst_fill", f4, 5'd0);
    c4 = 1; d4 = 1; a4 = 4'd15; tickn();
    chk("u4_s1_fill", f4, 5'd1);
    d4 = 0;
    for (int k = 2; k <= 16; k++) begin
      tick();
      chk($sformatf("u4_pos_fill[%0d]", k), f4, 5'(k - 1));
      tickn();
    end
    c4 = 0;
    chk("u4_q", q4, 1'b1); chk("u4_valid", v4, 1'b1); chk("u4_fill", f4, 5'd16);
    chk("u4_casc", cs4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
